// File: rtl/dmem_arb_if.sv
// dmem_arb_if: request/grant/read-back buses of both requesters plus the data-memory drive
interface dmem_arb_if #(
  parameter int DATA_BIT_WIDTH = 32
);
  logic                      aReq, aWr, aGnt, aRdValid, aErr;
  logic [DATA_BIT_WIDTH-1:0] aAddr, aData, aRdData;
  logic                      bReq, bWr, bGnt, bRdValid, bErr;
  logic [DATA_BIT_WIDTH-1:0] bAddr, bData, bRdData;
  logic                      memWr;
  logic [DATA_BIT_WIDTH-1:0] memAddr, memData, memRdData;
  modport slave (
    input  aReq, aWr, aAddr, aData, bReq, bWr, bAddr, bData, memRdData,
    output aGnt, aRdValid, aRdData, aErr, bGnt, bRdValid, bRdData, bErr, memWr, memAddr, memData
  );
  modport master (
    output aReq, aWr, aAddr, aData, bReq, bWr, bAddr, bData, memRdData,
    input  aGnt, aRdValid, aRdData, aErr, bGnt, bRdValid, bRdData, bErr, memWr, memAddr, memData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: A-priority arbiter with B starvation guard in front of the data memory; DMEM_ARB_RANGE_CHECK_EN enables out-of-range address errors
module dmem_arbiter #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2,
  parameter int MAX_WAIT       = 3
) (
  input logic       clk,
  input logic       reset_n,
  dmem_arb_if.slave bus
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  if (MAX_WAIT < 1 || MAX_WAIT > 15 || DMEMADDRBITS <= DMEMWORDBITS || DMEMADDRBITS > DATA_BIT_WIDTH) begin : g_bad_cfg
    $error("dmem_arbiter: unsupported parameter combination");
  end
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  logic                      valid_q, valid_d, wr_q, wr_d, owner_q, owner_d, err_q, err_d;
  logic [DATA_BIT_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic                      a_gnt, b_gnt, b_turn, gnt, rd_ok;
  logic [DATA_BIT_WIDTH-1:0] sel_addr, rd_data;
  // grant selection, next-state of the wait counter and the one-deep access pipeline (owner 1 = B)
  always_comb begin
    b_turn     = bus.bReq & (~bus.aReq | (wait_cnt_q == WAIT_MAX));
    b_gnt      = reset_n & b_turn;
    a_gnt      = reset_n & bus.aReq & ~b_turn;
    gnt        = a_gnt | b_gnt;
    sel_addr   = b_gnt ? bus.bAddr : bus.aAddr;
    wait_cnt_d = (bus.bReq & ~b_gnt) ? ((wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1) : 4'd0;
    valid_d    = gnt;
    wr_d       = b_gnt ? bus.bWr : bus.aWr;
    owner_d    = b_gnt;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    err_d      = gnt & ((sel_addr >> DMEMADDRBITS) != '0);
`else
    err_d      = 1'b0;
`endif
    mem_addr_d = gnt ? sel_addr : mem_addr_q;
    mem_data_d = gnt ? (b_gnt ? bus.bData : bus.aData) : mem_data_q;
  end
  // all state; async reset drops any in-flight access so a pending write never commits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 4'd0;
      valid_q    <= 1'b0;
      wr_q       <= 1'b0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= valid_d;
      wr_q       <= wr_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end
  // flagged accesses return a zero read response and never write
  always_comb begin
    rd_ok        = valid_q & (~wr_q | err_q);
    rd_data      = (rd_ok & ~err_q) ? bus.memRdData : '0;
    bus.aGnt     = a_gnt;
    bus.bGnt     = b_gnt;
    bus.memWr    = valid_q & wr_q & ~err_q;
    bus.memAddr  = mem_addr_d;
    bus.memData  = mem_data_d;
    bus.aRdValid = rd_ok & ~owner_q;
    bus.bRdValid = rd_ok & owner_q;
    bus.aRdData  = (rd_ok & ~owner_q) ? rd_data : '0;
    bus.bRdData  = (rd_ok & owner_q) ? rd_data : '0;
    bus.aErr     = valid_q & err_q & ~owner_q;
    bus.bErr     = valid_q & err_q & owner_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus reset, withdraw and range-check sequences against a word memory model
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  typedef struct {
    logic [31:0] ar, aw, aa, ad, br, bw, ba, bd;
    logic [31:0] ag, bg, mw, av, ard, bv, brd, ma;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:2047];
  logic [31:0] ma_q = '0;
  logic [31:0] md_q = '0;
  vec_t v [22];
  dmem_arb_if #(.DATA_BIT_WIDTH(32)) bus ();
  dmem_arbiter #(.DATA_BIT_WIDTH(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2), .MAX_WAIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    ma_q <= bus.memAddr;
    md_q <= bus.memData;
  end
  assign bus.memRdData = mem[ma_q[12:2]];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[0] = 32'd1;
    mem[1] = 32'd2;
    mem[2] = 32'd3;
    forever begin
      @(negedge clk);
      if (bus.memWr) mem[ma_q[12:2]] = md_q;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    @(posedge clk);
    #1;
    bus.aReq = ar; bus.aWr = aw; bus.aAddr = aa; bus.aData = ad;
    bus.bReq = br; bus.bWr = bw; bus.bAddr = ba; bus.bData = bd;
    #3;
  endtask
  task automatic step(input logic ar, input logic br, input logic ea, input logic eb, input string nm);
    drive(ar, 1'b0, 32'h0, 32'h0, br, 1'b0, 32'h4, 32'h0);
    chk({nm, " aGnt"}, 32'(bus.aGnt), 32'(ea));
    chk({nm, " bGnt"}, 32'(bus.bGnt), 32'(eb));
  endtask
  task automatic reset_episode(input logic wr, input string nm);
    drive(1'b1, wr, 32'h0, 32'hBAD, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({nm, " grant"}, 32'(bus.aGnt), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.aReq = 1'b1; bus.aWr = 1'b0; bus.aAddr = 32'h10;
    bus.bReq = 1'b1; bus.bAddr = 32'h8;
    #3;
    chk({nm, " rst aGnt"}, 32'(bus.aGnt), 32'd0);
    chk({nm, " rst bGnt"}, 32'(bus.bGnt), 32'd0);
    chk({nm, " rst memWr"}, 32'(bus.memWr), 32'd0);
    chk({nm, " rst aRdValid"}, 32'(bus.aRdValid), 32'd0);
    chk({nm, " rst aRdData"}, bus.aRdData, 32'd0);
    chk({nm, " rst memAddr"}, bus.memAddr, 32'd0);
    chk({nm, " rst memData"}, bus.memData, 32'd0);
    @(posedge clk);
    #4;
    chk({nm, " rst2 aRdValid"}, 32'(bus.aRdValid), 32'd0);
    chk({nm, " rst2 memWr"}, 32'(bus.memWr), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.aAddr = 32'h0; bus.bReq = 1'b0;
    #3;
    chk({nm, " post aGnt"}, 32'(bus.aGnt), 32'd1);
    chk({nm, " post memAddr"}, bus.memAddr, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({nm, " post aRdValid"}, 32'(bus.aRdValid), 32'd1);
    chk({nm, " post aRdData"}, bus.aRdData, 32'd1);
  endtask
  initial begin
    v[0]  = '{1, 1, 'h10, 'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h10};
    v[1]  = '{1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 'h10};
    v[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 'h10};
    v[3]  = '{0, 0, 0, 0, 1, 0, 'h0, 0, 0, 1, 0, 0, 0, 0, 0, 'h0};
    v[4]  = '{0, 0, 0, 0, 1, 0, 'h4, 0, 0, 1, 0, 0, 0, 1, 1, 'h4};
    v[5]  = '{0, 0, 0, 0, 1, 0, 'h8, 0, 0, 1, 0, 0, 0, 1, 2, 'h8};
    v[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h8};
    v[7]  = '{1, 1, 'h20, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h20};
    v[8]  = '{0, 0, 0, 0, 1, 0, 'h20, 0, 0, 1, 1, 0, 0, 0, 0, 'h20};
    v[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'h20};
    v[10] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 0, 0, 0, 0, 'h0};
    v[11] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 1, 1, 0, 0, 'h0};
    v[12] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 1, 1, 0, 0, 'h0};
    v[13] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 0, 1, 0, 1, 1, 0, 0, 'h4};
    v[14] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 0, 0, 1, 2, 'h0};
    v[15] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 1, 1, 0, 0, 'h0};
    v[16] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 1, 0, 0, 1, 1, 0, 0, 'h0};
    v[17] = '{1, 0, 'h0, 0, 1, 0, 'h4, 0, 0, 1, 0, 1, 1, 0, 0, 'h4};
    v[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'h4};
    v[19] = '{0, 0, 0, 0, 1, 1, 'h8, 'h77, 0, 1, 0, 0, 0, 0, 0, 'h8};
    v[20] = '{1, 0, 'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 'h8};
    v[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77, 0, 0, 'h8};
    bus.aReq = 1'b0; bus.aWr = 1'b0; bus.aAddr = '0; bus.aData = '0;
    bus.bReq = 1'b0; bus.bWr = 1'b0; bus.bAddr = '0; bus.bData = '0;
    #14;
    chk("reset aGnt", 32'(bus.aGnt), 32'd0);
    chk("reset memWr", 32'(bus.memWr), 32'd0);
    chk("reset memAddr", bus.memAddr, 32'd0);
    chk("reset memData", bus.memData, 32'd0);
    chk("reset aRdValid", 32'(bus.aRdValid), 32'd0);
    chk("reset bRdValid", 32'(bus.bRdValid), 32'd0);
    chk("reset bRdData", bus.bRdData, 32'd0);
    chk("reset aErr", 32'(bus.aErr), 32'd0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(v[i].ar[0], v[i].aw[0], v[i].aa, v[i].ad, v[i].br[0], v[i].bw[0], v[i].ba, v[i].bd);
      chk($sformatf("r%0d aGnt", i), 32'(bus.aGnt), v[i].ag);
      chk($sformatf("r%0d bGnt", i), 32'(bus.bGnt), v[i].bg);
      chk($sformatf("r%0d memWr", i), 32'(bus.memWr), v[i].mw);
      chk($sformatf("r%0d aRdValid", i), 32'(bus.aRdValid), v[i].av);
      chk($sformatf("r%0d aRdData", i), bus.aRdData, v[i].ard);
      chk($sformatf("r%0d bRdValid", i), 32'(bus.bRdValid), v[i].bv);
      chk($sformatf("r%0d bRdData", i), bus.bRdData, v[i].brd);
      chk($sformatf("r%0d memAddr", i), bus.memAddr, v[i].ma);
      chk($sformatf("r%0d errs", i), 32'({bus.aErr, bus.bErr}), 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, "wd0");
    step(1'b1, 1'b1, 1'b1, 1'b0, "wd1");
    step(1'b1, 1'b0, 1'b1, 1'b0, "wd2");
    step(1'b1, 1'b1, 1'b1, 1'b0, "wd3");
    step(1'b1, 1'b1, 1'b1, 1'b0, "wd4");
    step(1'b1, 1'b1, 1'b1, 1'b0, "wd5");
    step(1'b1, 1'b1, 1'b0, 1'b1, "wd6");
    step(1'b0, 1'b0, 1'b0, 1'b0, "wd7");
    reset_episode(1'b0, "rst_rd");
    reset_episode(1'b1, "rst_wr");
    drive(1'b1, 1'b1, 32'h4000, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rng aGnt", 32'(bus.aGnt), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rng memWr", 32'(bus.memWr), 32'(!RC));
    chk("rng aErr", 32'(bus.aErr), 32'(RC));
    chk("rng aRdValid", 32'(bus.aRdValid), 32'(RC));
    chk("rng aRdData", bus.aRdData, 32'd0);
    chk("rng bErr", 32'(bus.bErr), 32'd0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rng aErr drop", 32'(bus.aErr), 32'd0);
    chk("rng rd aGnt", 32'(bus.aGnt), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rng rd aRdValid", 32'(bus.aRdValid), 32'd1);
    chk("rng rd aRdData", bus.aRdData, RC ? 32'd1 : 32'h99);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory between the CPU load/store path (port A) and a secondary master (port B: DMA/debug loader).
- Sits directly in front of the data memory.
- Drives the memory's write enable, address and write data, and routes read data back to the winning requester.
- Fixed priority to A, with a starvation guard that forces a B grant after a bounded wait.

Parameters:
- DATA_BIT_WIDTH, 32, width of address and data buses.
- DMEMADDRBITS, 13, byte-address bits decoded by the data memory.
- DMEMWORDBITS, 2, byte-offset bits ignored by the memory (word aligned).
- MAX_WAIT, 3, max consecutive cycles B may request without a grant while A wins; 1..15.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- aReq  in  1  port A request; held until aGnt.
- aWr  in  1  A: 1=write, 0=read.
- aAddr  in  DATA_BIT_WIDTH  A byte address.
- aData  in  DATA_BIT_WIDTH  A write data.
- aGnt  out  1  A granted this cycle (combinational).
- aRdValid  out  1  A read data valid.
- aRdData  out  DATA_BIT_WIDTH  A read data.
- aErr  out  1  A access error (optional feature).
- bReq, bWr, bAddr, bData, bGnt, bRdValid, bRdData, bErr: same as A, for port B.
- memWr  out  1  memory write enable.
- memAddr  out  DATA_BIT_WIDTH  memory address (registered by the memory on posedge).
- memData  out  DATA_BIT_WIDTH  memory write data (registered by the memory on posedge).
- memRdData  in  DATA_BIT_WIDTH  memory read data, valid the cycle after the address is presented.

Behaviour:
Grant logic (combinational, from the request inputs and waitCnt):
- If only one requester asserts req, it is granted.
- If both assert: B is granted when waitCnt == MAX_WAIT; otherwise A is granted.
- At most one gnt high per cycle. No req means no gnt.

Memory drive:
- memAddr/memData: mux of the granted port in grant cycle N. With no grant they hold their last value.
- Request accepted in N: memory captures address/data at the posedge ending N.
- Write: memWr is registered and asserted in cycle N+1 only. The memory commits the write on the negedge of N+1.
- Read: xRdValid=1 in N+1 with xRdData=memRdData. When rdValid=0, rdData is 0.
- Back-to-back grants are legal every cycle with no bubble. A write accepted in N followed by a read of the same word in N+1 returns the new data in N+2.

waitCnt (width 4):
- Increments when bReq=1 and bGnt=0.
- Clears when bGnt=1 or bReq=0.
- Saturates at MAX_WAIT.

Pipeline register:
- Holds {valid, wr, owner, err} for the access accepted in the previous cycle.
- Drives memWr and rdValid routing.

Reset (async, reset_n=0):
- waitCnt=0; pipeline valid=0; memWr=0; memAddr=0; memData=0.
- aRdValid=bRdValid=0; rdData=0; err=0.
- gnt is forced 0 while in reset.
- Reset mid-operation: an accepted read loses its rdValid; an accepted write is not committed.

Requester rule: req, wr, addr and data are stable from req rise until the gnt cycle. Deasserting req before gnt withdraws the request, with no side effects.

Optional Feature:
DMEM_ARB_RANGE_CHECK_EN
- Defined:
  - A granted access with any nonzero address bit at or above DMEMADDRBITS is flagged in the pipeline register.
  - In N+1: memWr stays 0, rdValid=1 with rdData=0, and xErr=1 for one cycle.
  - Grant timing is unchanged.
- Undefined:
  - No check; upper address bits pass through unchanged.
  - aErr=bErr=0 constantly.

Test Plan:
1. After reset, A writes 0xDEADBEEF to 0x10, then reads 0x10 → aGnt same cycle for each; memWr=1 in cycle 2 only; aRdValid=1 with aRdData=0xDEADBEEF in cycle 3.
2. A and B both request continuously, MAX_WAIT=3 → grant sequence A,A,A,B,A,A,A,B; waitCnt sequence 1,2,3,0,...; bGnt never high while waitCnt<3.
3. B alone issues reads of 0x0, 0x4, 0x8 back to back (memory preloaded 1,2,3) → bGnt high 3 consecutive cycles; bRdValid in the next 3 cycles with data 1,2,3.
4. reset_n pulled low in the cycle after an A read is granted → aRdValid never asserts; all outputs 0 while low; a clean grant on the first cycle after release.
5. A write to 0x20 of 0x5 followed immediately by a B read of 0x20 → bRdData=0x5 two cycles after the write grant.
6. With DMEM_ARB_RANGE_CHECK_EN, A write to 0x4000 (DMEMADDRBITS=13) → aGnt=1; memWr stays 0; aErr=1 for one cycle; a later read of 0x0 is unchanged.
